// File: rtl/keypad_pkg.sv
// Shared types, constants and the seven-segment encoder for the keypad
// digit loader.
package keypad_pkg;

    // Key-acceptance FSM states.
    typedef enum logic [1:0] {
        ST_RELEASE,
        ST_ARMED,
        ST_HELD
    } key_state_t;

    localparam logic [3:0] KEY_NONE  = 4'd0;
    localparam logic [3:0] KEY_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns; element i is the pattern for digit i.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // Segment pattern for a BCD digit; blanked positions and non-BCD codes go dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit, input logic blank);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        if (!blank && (digit <= KEY_MAX)) begin
            pattern = SEG_TABLE[digit];
        end
        return pattern;
    endfunction

endpackage

// File: rtl/keypad_digit_loader_if.sv
// Key input / entry output bundle of the keypad digit loader.
interface keypad_digit_loader_if;
    logic       enable;
    logic [3:0] encoded;
    logic       clear_entry;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [2:0] digit_count;
    logic       full;
    logic       key_strobe;
    logic       reject_strobe;
    logic [6:0] seg;
    logic [3:0] an;

    // Keypad side / cook-timer consumer.
    modport master (
        output enable, encoded, clear_entry,
        input  min_tens, min_ones, sec_tens, sec_ones, digit_count, full,
        input  key_strobe, reject_strobe, seg, an
    );

    // The loader itself.
    modport slave (
        input  enable, encoded, clear_entry,
        output min_tens, min_ones, sec_tens, sec_ones, digit_count, full,
        output key_strobe, reject_strobe, seg, an
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit active-low seven-segment display.
// Position 0 is the rightmost digit (sec_ones).
module seg_scan_driver
    import keypad_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0][3:0] digits,
    input  logic [2:0]      digit_count,
    output logic [6:0]      seg,
    output logic [3:0]      an
);
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [RW-1:0] refresh_reg;
    logic [1:0]    scan_reg;
    logic [6:0]    seg_reg;
    logic [3:0]    an_reg;
    logic          blank;

    // Positions beyond the number of entered digits stay dark.
    assign blank = ({1'b0, scan_reg} >= digit_count);

    // Refresh counter, scan index and registered digit/segment selects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_reg <= '0;
            scan_reg    <= 2'd0;
            seg_reg     <= SEG_BLANK;
            an_reg      <= 4'hF;
        end else begin
            if (refresh_reg == RW'(REFRESH_DIV - 1)) begin
                refresh_reg <= '0;
                scan_reg    <= scan_reg + 2'd1;
            end else begin
                refresh_reg <= refresh_reg + 1'b1;
            end
            an_reg  <= ~(4'b0001 << scan_reg);
            seg_reg <= bcd_to_seg(digits[scan_reg], blank);
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;
endmodule

// File: rtl/keypad_digit_loader.sv
// Accepts debounced keypad digit presses, shifts them into a 4-digit MM:SS
// entry buffer and scans the entry onto a seven-segment display.
module keypad_digit_loader
    import keypad_pkg::*;
#(
    parameter int RELEASE_CYCLES = 4,
    parameter int REFRESH_DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keypad_digit_loader_if.slave  bus
);
    localparam int CW = $clog2(RELEASE_CYCLES + 1);

    key_state_t      state_reg, state_next;
    logic [CW-1:0]   rel_cnt_reg, rel_cnt_next;
    logic [3:0][3:0] digit_reg, digit_next;    // [0]=sec_ones .. [3]=min_tens
    logic [2:0]      count_reg, count_next;
    logic            full_reg;
    logic            key_strobe_reg, key_strobe_next;
    logic            reject_strobe_reg, reject_strobe_next;
    logic            is_digit;
    logic            accept;

    assign is_digit = (bus.encoded != KEY_NONE) && (bus.encoded <= KEY_MAX);

    // Next-state logic: release debounce, press acceptance and buffer shift.
    always_comb begin
        state_next         = state_reg;
        rel_cnt_next       = rel_cnt_reg;
        digit_next         = digit_reg;
        count_next         = count_reg;
        key_strobe_next    = 1'b0;
        reject_strobe_next = 1'b0;
        accept             = 1'b0;

        if (!bus.enable) begin
            state_next   = ST_RELEASE;
            rel_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_RELEASE: begin
                    if (bus.encoded == KEY_NONE) begin
                        if (rel_cnt_reg == CW'(RELEASE_CYCLES - 1)) begin
                            state_next   = ST_ARMED;
                            rel_cnt_next = '0;
                        end else begin
                            rel_cnt_next = rel_cnt_reg + 1'b1;
                        end
                    end else begin
                        rel_cnt_next = '0;
                    end
                end
                ST_ARMED: begin
                    if (is_digit) begin
                        state_next = ST_HELD;
                        if (!full_reg) begin
                            accept = 1'b1;
                        end else begin
                            reject_strobe_next = 1'b1;
                        end
                    end
                end
                ST_HELD: begin
                    if (bus.encoded == KEY_NONE) begin
                        state_next   = ST_RELEASE;
                        rel_cnt_next = '0;
                    end
                end
                default: begin
                    state_next   = ST_RELEASE;
                    rel_cnt_next = '0;
                end
            endcase
        end

        // A clear swallows a same-cycle accept; the FSM still treats the key as consumed.
        if (bus.clear_entry) begin
            digit_next = '0;
            count_next = 3'd0;
        end else if (accept && (count_reg != 3'd4)) begin
            digit_next      = {digit_reg[2:0], bus.encoded};
            count_next      = count_reg + 3'd1;
            key_strobe_next = 1'b1;
        end
    end

    // State, entry buffer and strobe registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= ST_RELEASE;
            rel_cnt_reg       <= '0;
            digit_reg         <= '0;
            count_reg         <= 3'd0;
            full_reg          <= 1'b0;
            key_strobe_reg    <= 1'b0;
            reject_strobe_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            rel_cnt_reg       <= rel_cnt_next;
            digit_reg         <= digit_next;
            count_reg         <= count_next;
            full_reg          <= (count_next == 3'd4);
            key_strobe_reg    <= key_strobe_next;
            reject_strobe_reg <= reject_strobe_next;
        end
    end

    assign bus.sec_ones      = digit_reg[0];
    assign bus.sec_tens      = digit_reg[1];
    assign bus.min_ones      = digit_reg[2];
    assign bus.min_tens      = digit_reg[3];
    assign bus.digit_count   = count_reg;
    assign bus.full          = full_reg;
    assign bus.key_strobe    = key_strobe_reg;
    assign bus.reject_strobe = reject_strobe_reg;

    seg_scan_driver #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (digit_reg),
        .digit_count (count_reg),
        .seg         (bus.seg),
        .an          (bus.an)
    );
endmodule

// File: tb/tb_keypad_digit_loader.sv
// Scoreboard bench for keypad_digit_loader: expected strobe events are queued
// when a key is driven and checked when the loader emits a strobe.
module tb_keypad_digit_loader;
    logic clk;
    logic rst_n;

    keypad_digit_loader_if bus_if ();

    keypad_digit_loader #(
        .RELEASE_CYCLES (4),
        .REFRESH_DIV    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        bit          rej;
        logic [15:0] digits;
        logic [2:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] m_digits    = 16'h0000;   // {min_tens,min_ones,sec_tens,sec_ones}
    logic [2:0]  m_count     = 3'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dut_digits();
        return {bus_if.min_tens, bus_if.min_ones, bus_if.sec_tens, bus_if.sec_ones};
    endfunction

    // Advance n clock edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Update the reference entry for a key press and queue the expected strobe.
    task automatic model_press(input logic [3:0] key);
        exp_t e;
        if (m_count < 3'd4) begin
            m_digits = {m_digits[11:0], key};
            m_count  = m_count + 3'd1;
            e.rej    = 1'b0;
        end else begin
            e.rej    = 1'b1;
        end
        e.digits = m_digits;
        e.cnt    = m_count;
        exp_q.push_back(e);
    endtask

    // Clean press: hold the key, then release long enough to re-arm.
    task automatic press(input logic [3:0] key);
        model_press(key);
        bus_if.encoded = key;
        tick(3);
        bus_if.encoded = 4'd0;
        tick(6);
    endtask

    task automatic clear_buffer();
        bus_if.clear_entry = 1'b1;
        tick(1);
        bus_if.clear_entry = 1'b0;
        m_digits = 16'h0000;
        m_count  = 3'd0;
        tick(1);
    endtask

    task automatic check_entry(input string tag);
        check({tag, "_digits"}, dut_digits(), m_digits);
        check({tag, "_count"}, bus_if.digit_count, m_count);
        check({tag, "_full"}, bus_if.full, (m_count == 3'd4));
    endtask

    // Strobe monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus_if.key_strobe || bus_if.reject_strobe)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {bus_if.key_strobe, bus_if.reject_strobe}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", {bus_if.key_strobe, bus_if.reject_strobe},
                      e.rej ? 2'b01 : 2'b10);
                check("strobe_digits", dut_digits(), e.digits);
                check("strobe_count", bus_if.digit_count, e.cnt);
                $display("txn %s digits=%04h count=%0d", e.rej ? "reject" : "accept",
                         dut_digits(), bus_if.digit_count);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] prev_an;
        int         since;
        int         changes;

        rst_n              = 1'b0;
        bus_if.enable      = 1'b1;
        bus_if.encoded     = 4'd5;
        bus_if.clear_entry = 1'b0;
        tick(2);
        check_entry("reset");
        check("reset_seg", bus_if.seg, 7'h7F);
        check("reset_an", bus_if.an, 4'hF);
        check("reset_strobes", {bus_if.key_strobe, bus_if.reject_strobe}, 2'b00);

        // Key held through reset is ignored; after release it is accepted once.
        rst_n = 1'b1;
        tick(10);
        bus_if.encoded = 4'd0;
        tick(4);
        press(4'd5);
        check_entry("after_reset_key");

        // Fill to 12:34, then a fifth key is rejected.
        clear_buffer();
        check_entry("clear1");
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        check_entry("full_1234");
        press(4'd7);
        check_entry("reject_7");

        // Bounce: too-short release then the same key again.
        clear_buffer();
        model_press(4'd3);
        bus_if.encoded = 4'd3;
        tick(3);
        bus_if.encoded = 4'd0;
        tick(2);
        bus_if.encoded = 4'd3;
        tick(3);
        bus_if.encoded = 4'd0;
        tick(6);
        check_entry("bounce");

        // Clear colliding with an accepted 6 consumes the key.
        clear_buffer();
        bus_if.encoded     = 4'd6;
        bus_if.clear_entry = 1'b1;
        tick(1);
        bus_if.clear_entry = 1'b0;
        m_digits = 16'h0000;
        m_count  = 3'd0;
        tick(3);
        check_entry("clear_collide");
        bus_if.encoded = 4'd0;
        tick(6);
        press(4'd6);
        check_entry("after_collide");

        // Display scan with a single entered 8.
        clear_buffer();
        press(4'd8);
        prev_an = bus_if.an;
        since   = 0;
        changes = 0;
        for (int i = 0; i < 48; i++) begin
            tick(1);
            since++;
            if (bus_if.an != prev_an) begin
                check("an_step", bus_if.an, {prev_an[2:0], prev_an[3]});
                if (changes > 0) check("an_period", since, 4);
                changes++;
                since   = 0;
                prev_an = bus_if.an;
            end
            check("seg_vs_an", bus_if.seg, (bus_if.an == 4'b1110) ? 7'h00 : 7'h7F);
        end
        check("an_changes", (changes >= 10), 1'b1);

        // Disable while held, then an invalid code after re-arming.
        model_press(4'd2);
        bus_if.encoded = 4'd2;
        tick(2);
        bus_if.enable = 1'b0;
        tick(3);
        bus_if.enable = 1'b1;
        tick(2);
        bus_if.encoded = 4'd0;
        tick(6);
        bus_if.encoded = 4'd12;
        tick(3);
        bus_if.encoded = 4'd0;
        tick(6);
        check_entry("after_disable");
        press(4'd1);
        check_entry("rearmed");

        tick(5);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/keypad_digit_loader.md
Name: keypad_digit_loader

Overview:
- Consumer end of the keypad encoder path: takes the 4-bit key code (1–9 = digit, 0 = no key) and detects discrete key presses with release debounce.
- Shifts accepted digits into a 4-digit MM:SS entry buffer.
- Drives a time-multiplexed, active-low 4-digit seven-segment display of the entry.
- Sits between the keypad encoder and the cook-timer load logic.

Parameters:
- RELEASE_CYCLES, 4: consecutive no-key cycles required before the next press is accepted (min 1).
- REFRESH_DIV, 50000: clock cycles each display digit is lit (min 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- enable  input  1  entry enabled; low = entry disarmed
- encoded  input  4  key code from encoder: 0 none, 1–9 digit, 10–15 invalid
- clear_entry  input  1  synchronous clear of entry buffer
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD entry digits
- digit_count  output  3  digits entered, 0..4
- full  output  1  digit_count == 4
- key_strobe  output  1  one-cycle pulse per accepted digit
- reject_strobe  output  1  one-cycle pulse when a key is pressed while full
- seg  output  7  {g,f,e,d,c,b,a}, active-low
- an  output  4  digit select, active-low one-hot; an[0] = sec_ones … an[3] = min_tens

Behaviour:
- Reset (rst_n=0 at an edge):
  - All four digits = 0, digit_count = 0, full = 0, both strobes = 0.
  - seg = 7'h7F, an = 4'hF, scan index = 0, refresh count = 0, release count = 0.
  - FSM enters ST_RELEASE.
  - Reset wins over every other input.
- FSM (all outputs registered):
  - ST_RELEASE:
    - encoded==0 increments release count; any nonzero code resets it to 0.
    - When count reaches RELEASE_CYCLES, go to ST_ARMED.
    - A key held through reset is therefore never accepted.
  - ST_ARMED:
    - encoded in 1..9 with full=0: accept. Shift on the same edge: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=encoded. digit_count+1, key_strobe=1 for one cycle, go to ST_HELD.
    - encoded in 1..9 with full=1: no shift, reject_strobe=1 for one cycle, go to ST_HELD.
    - encoded 0 or 10–15: stay in ST_ARMED.
  - ST_HELD:
    - encoded==0: go to ST_RELEASE with count cleared.
    - Any other code (including a different digit): stay in ST_HELD, no action.
  - Latency: the code sampled in ST_ARMED at edge N is visible on digits/strobe after edge N.
- enable=0:
  - FSM is forced to ST_RELEASE, count 0, no strobes.
  - Digits, digit_count and display are held and keep refreshing.
- clear_entry=1:
  - Digits = 0, digit_count = 0, full = 0.
  - Overrides a same-cycle accept: no shift, no key_strobe; the FSM still goes to ST_HELD, so the key is consumed.
  - Does not otherwise alter FSM state.
- full is derived registered from digit_count; digit_count saturates at 4.
- Display:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - At wrap, scan index advances 0→1→2→3→0.
  - an = ~(1<<scan), registered one cycle after scan index.
  - Position i shows its digit's pattern if i < digit_count, else blank (7'h7F).
  - Codes >9 never reach the buffer.
- Segment patterns (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

Decomposition:
- Package keypad_pkg:
  - FSM state enum (ST_RELEASE, ST_ARMED, ST_HELD).
  - KEY_NONE = 4'd0, SEG_BLANK = 7'h7F, and the seven-segment constant table.
  - Function bcd_to_seg(digit, blank).
- One sub-module: seg_scan_driver, holding the refresh counter, scan index, digit mux and an/seg registers.
- Key FSM and entry buffer stay in the top.

Test Plan:
- Reset with encoded=5 held for 10 cycles, then 0 for 4 cycles, then 5 → no strobe during the hold; exactly one key_strobe afterwards, sec_ones=5, digit_count=1.
- Keys 1,2,3,4, each with a ≥4-cycle release → digits 1,2,3,4 (MM:SS 12:34) and full=1. Then key 7 → reject_strobe pulse, no key_strobe, digits unchanged.
- Bounce with RELEASE_CYCLES=4: after an accepted 3, drive 0 for 2 cycles then 3 again → no second strobe; digit_count stays 1.
- clear_entry in the same cycle as an accepted 6 → all digits 0, count 0, no key_strobe. A following 6 without release → ignored; after release → accepted.
- Display with REFRESH_DIV=4, after entering 8:
  - an steps 1110→1101→1011→0111 every 4 cycles.
  - seg=0000000 while an[0] is low, 1111111 on the other positions.
- enable dropped while in ST_HELD, then code 12 after re-enable and release → no strobe, buffer unchanged, FSM in ST_RELEASE then ST_ARMED.
